// File: rtl/mac_pkg.sv
// Shared constants, state encoding and sizing helper for the multi-cycle MAC engine.
package mac_pkg;

  localparam int unsigned OP_W  = 64;
  localparam int unsigned RES_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned count_w(input int unsigned iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

endpackage

// File: rtl/mac_step.sv
// One shift-add iteration: folds a_sh times the low multiplier slice into acc.
// Ports:
//   acc_i     - running 128-bit accumulator
//   a_sh_i    - multiplicand already shifted to this slice's weight
//   b_slice_i - BITS_PER_CYCLE low bits of the remaining multiplier
//   acc_c     - next accumulator value, truncated to 128 bits
module mac_step
  import mac_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic [RES_W-1:0]          acc_i,
  input  logic [RES_W-1:0]          a_sh_i,
  input  logic [BITS_PER_CYCLE-1:0] b_slice_i,
  output logic [RES_W-1:0]          acc_c
);

  logic [RES_W-1:0] pp_c;

  // Partial product plus accumulate; wraps modulo 2^128.
  always_comb begin
    pp_c  = a_sh_i * RES_W'(b_slice_i);
    acc_c = acc_i + pp_c;
  end

endmodule

// File: rtl/mac_sequencer.sv
// Multi-cycle unsigned multiply-accumulate: Z = (A*B + C) mod 2^128.
// Retires BITS_PER_CYCLE multiplier bits per clock with a fixed latency of
// 64/BITS_PER_CYCLE clocks from the accepting edge to out_valid.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake (A multiplicand, B multiplier, C addend)
//   out_valid, out_ready- result handshake, Z held while out_valid and not taken
//   busy                - high while iterating
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  input  logic [RES_W-1:0]  C,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  Z,
  output logic              busy
);

  localparam int unsigned ITER  = OP_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = count_w(ITER);

  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
          BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("mac_sequencer: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] a_sh_q, a_sh_d;
  logic [OP_W-1:0]  b_rem_q, b_rem_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RES_W-1:0] z_q, z_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             idle_rdy_q, idle_rdy_d;
  logic [RES_W-1:0] step_c;
  logic             accept_c;

  mac_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .acc_i     (acc_q),
    .a_sh_i    (a_sh_q),
    .b_slice_i (b_rem_q[BITS_PER_CYCLE-1:0]),
    .acc_c     (step_c)
  );

  // Ready in IDLE is registered (low through reset); in DONE it follows out_ready
  // so a new operand set can be taken on the same edge the result is consumed.
  assign in_ready  = idle_rdy_q | ((state_q == DONE) & out_ready);
  assign accept_c  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign Z         = z_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_rem_d = b_rem_q;
    count_d = count_q;
    z_d     = z_q;

    case (state_q)
      IDLE: ;
      CALC: begin
        acc_d   = step_c;
        a_sh_d  = a_sh_q << BITS_PER_CYCLE;
        b_rem_d = b_rem_q >> BITS_PER_CYCLE;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(ITER - 1)) begin
          state_d = DONE;
          z_d     = step_c;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Operand capture, from IDLE or back-to-back out of DONE.
    if (accept_c) begin
      state_d = CALC;
      acc_d   = C;
      a_sh_d  = RES_W'(A);
      b_rem_d = B;
      count_d = '0;
    end

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == CALC);
    idle_rdy_d  = (state_d == IDLE);
  end

  // State and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      a_sh_q      <= '0;
      b_rem_q     <= '0;
      count_q     <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      idle_rdy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_sh_q      <= a_sh_d;
      b_rem_q     <= b_rem_d;
      count_q     <= count_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      idle_rdy_q  <= idle_rdy_d;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed and random checks of mac_sequencer at BITS_PER_CYCLE = 4, 1 and 16.
module tb_mac_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv_main, iv_aux, out_ready;
  logic [63:0]  a_in, b_in;
  logic [127:0] c_in;
  logic [2:0]   ir, ov, bz;
  logic [127:0] zz [3];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Index 0: BITS_PER_CYCLE=4, 1: BITS_PER_CYCLE=1, 2: BITS_PER_CYCLE=16
  mac_sequencer #(.BITS_PER_CYCLE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_main), .in_ready(ir[0]),
    .A(a_in), .B(b_in), .C(c_in), .out_valid(ov[0]), .out_ready(out_ready),
    .Z(zz[0]), .busy(bz[0])
  );
  mac_sequencer #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(ir[1]),
    .A(a_in), .B(b_in), .C(c_in), .out_valid(ov[1]), .out_ready(out_ready),
    .Z(zz[1]), .busy(bz[1])
  );
  mac_sequencer #(.BITS_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(ir[2]),
    .A(a_in), .B(b_in), .C(c_in), .out_valid(ov[2]), .out_ready(out_ready),
    .Z(zz[2]), .busy(bz[2])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set to the main DUT and wait for its result.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [127:0] c, input logic [127:0] exp);
    int lat;
    a_in = a; b_in = b; c_in = c;
    iv_main = 1'b1;
    tick();
    iv_main = 1'b0;
    check({tag, "_busy"}, 128'(bz[0]), 128'd1);
    check({tag, "_inrdy_lo"}, 128'(ir[0]), 128'd0);
    lat = 0;
    while (!ov[0] && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'd16);
    check({tag, "_z"}, zz[0], exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, lat;
    logic [2:0]   done;
    logic [63:0]  ra, rb;
    logic [127:0] rc, ex;
    int exp_lat [3];
    exp_lat[0] = 16; exp_lat[1] = 64; exp_lat[2] = 4;

    rst_n = 1'b0; iv_main = 1'b0; iv_aux = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; c_in = '0;
    #12;
    check("rst_inrdy", 128'(ir[0]), 128'd0);
    check("rst_ovalid", 128'(ov[0]), 128'd0);
    check("rst_busy", 128'(bz[0]), 128'd0);
    check("rst_z", zz[0], 128'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check("post_rst_inrdy", 128'(ir[0]), 128'd1);

    do_op("zero", 64'h0, 64'h0, 128'h0, 128'h0);
    tick();

    do_op("small", 64'h3, 64'h5, 128'h7, 128'h16);
    tick();
    check("small_ov_drop", 128'(ov[0]), 128'd0);
    check("small_inrdy_back", 128'(ir[0]), 128'd1);

    do_op("bzero", 64'h9e671e3d752a5420, 64'h0,
          128'h0026c160f19eb5f182168f26ab92c99b, 128'h0026c160f19eb5f182168f26ab92c99b);
    tick();

    do_op("ones", 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff,
          128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff,
          128'hffff_ffff_ffff_fffe_0000_0000_0000_0000);
    tick();

    // Backpressure: result held, inputs ignored.
    out_ready = 1'b0;
    do_op("bp", 64'd10, 64'd20, 128'd1, 128'd201);
    for (int i = 0; i < 5; i++) begin
      iv_main = 1'b1;
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
      c_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check($sformatf("bp_hold_ov%0d", i), 128'(ov[0]), 128'd1);
      check($sformatf("bp_hold_inrdy%0d", i), 128'(ir[0]), 128'd0);
      check($sformatf("bp_hold_z%0d", i), zz[0], 128'd201);
    end

    // Back-to-back: take result and accept new operands on one edge.
    a_in = 64'd2; b_in = 64'd3; c_in = 128'd4;
    out_ready = 1'b1;
    #1;
    check("b2b_inrdy", 128'(ir[0]), 128'd1);
    tick();
    iv_main = 1'b0;
    check("b2b_ov_drop", 128'(ov[0]), 128'd0);
    check("b2b_busy", 128'(bz[0]), 128'd1);
    lat = 0;
    while (!ov[0] && lat < 100) begin
      tick();
      lat++;
    end
    check("b2b_lat", 128'(lat), 128'd16);
    check("b2b_z", zz[0], 128'd10);
    tick();

    // Asynchronous reset at count=7 aborts the operation.
    a_in = 64'h1234_5678_9abc_def0; b_in = 64'hfedc_ba98_7654_3210; c_in = 128'd99;
    iv_main = 1'b1;
    tick();
    iv_main = 1'b0;
    repeat (7) tick();
    check("abort_busy_pre", 128'(bz[0]), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ov", 128'(ov[0]), 128'd0);
    check("abort_busy", 128'(bz[0]), 128'd0);
    check("abort_z", zz[0], 128'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check("abort_inrdy", 128'(ir[0]), 128'd1);
    cnt = 0;
    repeat (40) begin
      tick();
      if (ov[0]) cnt++;
    end
    check("abort_no_stale", 128'(cnt), 128'd0);

    // Random vectors against A*B+C mod 2^128 on all three widths.
    for (int v = 0; v < 300; v++) begin
      ra = {$urandom, $urandom};
      rb = (v % 50 == 7) ? 64'h0 : {$urandom, $urandom};
      rc = {$urandom, $urandom, $urandom, $urandom};
      ex = 128'(ra) * 128'(rb) + rc;
      a_in = ra; b_in = rb; c_in = rc;
      check($sformatf("rnd%0d_inrdy", v), 128'(ir), 128'd7);
      iv_main = 1'b1; iv_aux = 1'b1;
      tick();
      iv_main = 1'b0; iv_aux = 1'b0;
      check($sformatf("rnd%0d_busy", v), 128'(bz), 128'd7);
      done = 3'b000;
      lat = 0;
      while (done != 3'b111 && lat < 80) begin
        tick();
        lat++;
        for (int k = 0; k < 3; k++) begin
          if (ov[k] && !done[k]) begin
            done[k] = 1'b1;
            check($sformatf("rnd%0d_z%0d", v, k), zz[k], ex);
            check($sformatf("rnd%0d_lat%0d", v, k), 128'(lat), 128'(exp_lat[k]));
          end
        end
      end
      if (done != 3'b111) check($sformatf("rnd%0d_timeout", v), 128'(done), 128'd7);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
